pwm_cfg_sequencer: RTL and testbench
====================================

PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

Interface
REQ-001 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 rx_data  in  8  byte received from the SPI block, sys_clk-synchronous.
REQ-004 rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-005 cs_n  in  1  SPI chip select, synchronized; high means no frame is in progress.
REQ-006 period_wrap  in  1  one-cycle pulse when the shared 15-bit PWM counter wraps to 0.
REQ-007 tx_data  out  8  byte for the SPI block to shift out next.
REQ-008 tx_load  out  1  one-cycle pulse; tx_data is valid in that cycle.
REQ-009 duty  out  112  active duty, 16 bits per channel; channel n occupies bits [16n+15:16n].
REQ-010 ch_en  out  7  active enable, one bit per channel.
REQ-011 busy  out  1  high while the FSM is not in IDLE.
REQ-012 err  out  1  one-cycle pulse on a bad command or an aborted frame.

Function
REQ-013 Frame format: the command byte comes first, then two data bytes, high byte first.
REQ-014 Command byte fields: bit7 = write(1)/read(0); bits4:2 = channel 0..6; bits1:0 = register select (00 duty, 01 ctrl); bits6:5 are ignored.
REQ-015 FSM states: IDLE, CMD_CHK, WR_HI, WR_LO, COMMIT, RD_HI, RD_LO.
REQ-016 IDLE: on rx_valid with cs_n low, latch the command and go to CMD_CHK.
REQ-017 CMD_CHK lasts one cycle and routes as follows:
- channel 7, or register select 1x: pulse err, go to IDLE.
- write: go to WR_HI.
- read: go to RD_HI, with tx_data = shadow[15:8] and tx_load high in that same cycle.
REQ-018 WR_HI: on rx_valid, latch the high byte and go to WR_LO.
REQ-019 WR_LO: on rx_valid, latch the low byte and go to COMMIT.
REQ-020 COMMIT lasts one cycle and returns to IDLE:
- duty register: shadow duty = {hi, lo}.
- ctrl register: shadow enable = lo[0].
- in both cases, set the channel's pending bit.
REQ-021 RD_HI: on rx_valid (dummy byte), present tx_data = shadow[7:0] with tx_load the same cycle, and go to RD_LO.
REQ-022 RD_LO: on rx_valid, go to IDLE; tx_load stays low.
REQ-023 Reading the ctrl register returns {15'b0, shadow_en}.
REQ-024 Latency: a write becomes active on the first period_wrap after COMMIT; it is never active mid-period.
REQ-025 On period_wrap, every channel with pending set copies shadow to active and clears pending; channels without pending are unchanged.
REQ-026 If COMMIT and period_wrap coincide on the same channel, active takes the new value and pending ends clear.
REQ-027 If cs_n goes high in any state other than IDLE:
- return to IDLE next cycle;
- pulse err;
- make no shadow or pending change.
REQ-028 cs_n high during COMMIT does not count as an abort; the commit completes.
REQ-029 rx_valid while cs_n is high is ignored.
REQ-030 Extra rx_valid bytes after a frame completes start a new frame and are treated as a command byte.
REQ-031 err, tx_load and all state transitions are registered outputs; no combinational path runs from an input to an output.

Reset
REQ-032 During rst, and after it is released:
- FSM = IDLE;
- all shadow and active duty = 16'h0000;
- all enable = 0; all pending = 0;
- tx_data = 8'h00; tx_load, busy, err = 0.
REQ-033 rst asserted mid-frame discards the frame; nothing is written.

Structure
REQ-034 Shared package pwm_pkg holds:
- NUM_CH = 7, DUTY_W = 16;
- register-select codes REG_DUTY = 2'b00 and REG_CTRL = 2'b01;
- the FSM state encoding.
REQ-035 Sub-module pwm_chan_regs holds one channel's shadow/active duty, enable and pending, plus its wrap-update logic; it is instantiated NUM_CH times.

Verification
REQ-036 Write and wrap:
- stimulus: cs_n low; bytes 0x88, 0x12, 0x34; then period_wrap.
- response: duty[47:32] stays 0 until the wrap, then reads 0x1234 at the first wrap.
REQ-037 Readback:
- stimulus: after REQ-036, send 0x08, 0x00, 0x00.
- response: tx_load pulses twice, with tx_data 0x12 then 0x34.
REQ-038 Bad command:
- stimulus: command 0x9C (channel 7).
- response: err pulses once, FSM returns to IDLE, and no shadow changes.
- stimulus: command 0x82.
- response: same as above.
REQ-039 Abort:
- stimulus: 0x85, 0x00, then cs_n high before the third byte.
- response: err pulses, ch_en[1] remains 0 after the next wrap, and busy drops.
REQ-040 Coincidence:
- stimulus: period_wrap asserted in the COMMIT cycle of a channel-0 duty write of 0xFFFF.
- response: duty[15:0] = 0xFFFF the next cycle, and pending = 0.
REQ-041 Reset mid-frame:
- stimulus: rst pulse during WR_LO.
- response: all outputs are at their reset values and the next frame decodes normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM configuration sequencer:
//   - channel count and duty width
//   - register-select codes carried in the command byte
//   - FSM state encoding and the decoded command record
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int NUM_CH = 7;
  localparam int DUTY_W = 16;

  localparam logic [1:0] REG_DUTY = 2'b00;
  localparam logic [1:0] REG_CTRL = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD_CHK = 3'd1,
    WR_HI   = 3'd2,
    WR_LO   = 3'd3,
    COMMIT  = 3'd4,
    RD_HI   = 3'd5,
    RD_LO   = 3'd6
  } state_e;

  // Decoded command byte: bit7 write, bits4:2 channel, bits1:0 register.
  // Bits 6:5 carry no meaning and are not stored.
  typedef struct packed {
    logic       write;
    logic [2:0] chan;
    logic [1:0] sel;
  } cmd_t;

endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// pwm_cfg_sequencer_if
// Byte-level link between the SPI shifter and the configuration sequencer.
//
// Handshake: rx_valid is a one-cycle pulse qualifying rx_data in that cycle;
// there is no back-pressure, the sequencer takes every byte it is offered.
// tx_load is a one-cycle pulse qualifying tx_data in that cycle; the SPI
// block must capture tx_data whenever tx_load is high. cs_n high means no
// frame is in progress.
//
//   master : SPI block side  (drives rx_data, rx_valid, cs_n)
//   slave  : sequencer side  (drives tx_data, tx_load)
// -----------------------------------------------------------------------------
interface pwm_cfg_sequencer_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs_n;
  logic [7:0] tx_data;
  logic       tx_load;

  modport master (
    output rx_data,
    output rx_valid,
    output cs_n,
    input  tx_data,
    input  tx_load
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  cs_n,
    output tx_data,
    output tx_load
  );

endinterface

// File: rtl/pwm_chan_regs.sv
// -----------------------------------------------------------------------------
// pwm_chan_regs
// One PWM channel's register set: shadow duty/enable written by the
// sequencer, active duty/enable seen by the PWM generator, and a pending
// flag that moves shadow to active on the next period wrap.
//
// Ports:
//   sys_clk, rst          clock, asynchronous active-high reset
//   wr_duty_i             one-cycle strobe: shadow duty <= wdata_i
//   wr_ctrl_i             one-cycle strobe: shadow enable <= wdata_i[0]
//   wdata_i               write data {hi, lo}
//   wrap_i                PWM counter wrapped to 0 this cycle
//   shadow_duty_o/en_o    shadow values (readback path)
//   active_duty_o/en_o    active values (PWM generator)
//   pending_o             shadow holds an update not yet made active
// -----------------------------------------------------------------------------
module pwm_chan_regs
  import pwm_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              wr_duty_i,
  input  logic              wr_ctrl_i,
  input  logic [DUTY_W-1:0] wdata_i,
  input  logic              wrap_i,
  output logic [DUTY_W-1:0] shadow_duty_o,
  output logic              shadow_en_o,
  output logic [DUTY_W-1:0] active_duty_o,
  output logic              active_en_o,
  output logic              pending_o
);

  logic [DUTY_W-1:0] shadow_duty_q, shadow_duty_d;
  logic              shadow_en_q, shadow_en_d;
  logic [DUTY_W-1:0] active_duty_q, active_duty_d;
  logic              active_en_q, active_en_d;
  logic              pending_q, pending_d;

  // A write landing in the same cycle as a wrap is folded into that wrap:
  // the active copy is taken from the post-write shadow and pending ends
  // clear, so no update is ever left waiting a whole extra period.
  always_comb begin
    shadow_duty_d = wr_duty_i ? wdata_i : shadow_duty_q;
    shadow_en_d   = wr_ctrl_i ? wdata_i[0] : shadow_en_q;
    pending_d     = pending_q | wr_duty_i | wr_ctrl_i;
    active_duty_d = active_duty_q;
    active_en_d   = active_en_q;
    if (wrap_i && pending_d) begin
      active_duty_d = shadow_duty_d;
      active_en_d   = shadow_en_d;
      pending_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      shadow_duty_q <= '0;
      shadow_en_q   <= 1'b0;
      active_duty_q <= '0;
      active_en_q   <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      shadow_duty_q <= shadow_duty_d;
      shadow_en_q   <= shadow_en_d;
      active_duty_q <= active_duty_d;
      active_en_q   <= active_en_d;
      pending_q     <= pending_d;
    end
  end

  assign shadow_duty_o = shadow_duty_q;
  assign shadow_en_o   = shadow_en_q;
  assign active_duty_o = active_duty_q;
  assign active_en_o   = active_en_q;
  assign pending_o     = pending_q;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_cfg_sequencer
// Decodes three-byte SPI frames (command, data hi, data lo) into writes and
// reads of per-channel PWM shadow registers. Shadow values become active on
// the first period wrap after the write commits.
//
// Ports:
//   sys_clk, rst      clock, asynchronous active-high reset
//   spi               byte link to the SPI block (slave side)
//   period_wrap       shared PWM counter wrapped to 0 this cycle
//   duty              active duty, channel n at [16n+15:16n]
//   ch_en             active enable per channel
//   busy              FSM not in IDLE
//   err               one-cycle pulse on bad command or aborted frame
//   dbg_state_o       current FSM state
//   dbg_pending_o     per-channel pending flags
// -----------------------------------------------------------------------------
module pwm_cfg_sequencer
  import pwm_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     rst,
  pwm_cfg_sequencer_if.slave       spi,
  input  logic                     period_wrap,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic [NUM_CH-1:0]        ch_en,
  output logic                     busy,
  output logic                     err,
  output state_e                   dbg_state_o,
  output logic [NUM_CH-1:0]        dbg_pending_o
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_load_q, tx_load_d;
  logic        err_q, err_d;

  logic        wr_duty_stb;
  logic        wr_ctrl_stb;
  logic        abort;
  logic [15:0] rd_word;

  logic [DUTY_W-1:0] shadow_duty [NUM_CH];
  logic [NUM_CH-1:0] shadow_en;

  // cs_n rising mid-frame abandons the frame. COMMIT is exempt: the data is
  // already complete, so the write is allowed to finish.
  assign abort = spi.cs_n && (state_q != IDLE) && (state_q != COMMIT);

  // Readback word for the addressed channel. Channel 7 never reaches a read
  // state, so the all-zero default is never presented.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_q.chan == 3'(i)) begin
        rd_word = (cmd_q.sel == REG_CTRL) ? {15'b0, shadow_en[i]} : shadow_duty[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    err_d       = 1'b0;
    wr_duty_stb = 1'b0;
    wr_ctrl_stb = 1'b0;

    if (abort) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (spi.rx_valid && !spi.cs_n) begin
            cmd_d.write = spi.rx_data[7];
            cmd_d.chan  = spi.rx_data[4:2];
            cmd_d.sel   = spi.rx_data[1:0];
            state_d     = CMD_CHK;
          end
        end
        CMD_CHK: begin
          if ((cmd_q.chan >= 3'(NUM_CH)) || cmd_q.sel[1]) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cmd_q.write) begin
            state_d = WR_HI;
          end else begin
            // First read byte is queued now so it is ready before the
            // master clocks in the dummy byte.
            tx_data_d = rd_word[15:8];
            tx_load_d = 1'b1;
            state_d   = RD_HI;
          end
        end
        WR_HI: begin
          if (spi.rx_valid) begin
            hi_d    = spi.rx_data;
            state_d = WR_LO;
          end
        end
        WR_LO: begin
          if (spi.rx_valid) begin
            lo_d    = spi.rx_data;
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          wr_duty_stb = (cmd_q.sel == REG_DUTY);
          wr_ctrl_stb = (cmd_q.sel == REG_CTRL);
          state_d     = IDLE;
        end
        RD_HI: begin
          if (spi.rx_valid) begin
            tx_data_d = rd_word[7:0];
            tx_load_d = 1'b1;
            state_d   = RD_LO;
          end
        end
        RD_LO: begin
          if (spi.rx_valid) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic              sel_ch;
    logic [DUTY_W-1:0] active_duty;

    assign sel_ch = (cmd_q.chan == 3'(g));

    pwm_chan_regs u_regs (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .wr_duty_i     (wr_duty_stb && sel_ch),
      .wr_ctrl_i     (wr_ctrl_stb && sel_ch),
      .wdata_i       ({hi_q, lo_q}),
      .wrap_i        (period_wrap),
      .shadow_duty_o (shadow_duty[g]),
      .shadow_en_o   (shadow_en[g]),
      .active_duty_o (active_duty),
      .active_en_o   (ch_en[g]),
      .pending_o     (dbg_pending_o[g])
    );

    assign duty[g*DUTY_W +: DUTY_W] = active_duty;
  end

  assign spi.tx_data  = tx_data_q;
  assign spi.tx_load  = tx_load_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_cfg_sequencer
// Directed bench for pwm_cfg_sequencer: frame writes and reads, wrap-timed
// activation, bad commands, cs_n aborts, write/wrap coincidence and reset
// in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_pwm_cfg_sequencer;
  import pwm_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  logic                     period_wrap;
  logic [NUM_CH*DUTY_W-1:0] duty;
  logic [NUM_CH-1:0]        ch_en;
  logic                     busy;
  logic                     err;
  state_e                   dbg_state_o;
  logic [NUM_CH-1:0]        dbg_pending_o;

  pwm_cfg_sequencer_if spi_if ();

  pwm_cfg_sequencer dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .spi           (spi_if),
    .period_wrap   (period_wrap),
    .duty          (duty),
    .ch_en         (ch_en),
    .busy          (busy),
    .err           (err),
    .dbg_state_o   (dbg_state_o),
    .dbg_pending_o (dbg_pending_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] exp_act [NUM_CH];
  logic [NUM_CH-1:0] exp_en;

  function automatic logic [NUM_CH*DUTY_W-1:0] exp_duty_vec();
    logic [NUM_CH*DUTY_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*DUTY_W +: DUTY_W] = exp_act[i];
    return v;
  endfunction

  // Monitors sample registered outputs on the falling edge.
  always @(negedge sys_clk) begin
    if (err === 1'b1) err_cnt++;
    if (spi_if.tx_load === 1'b1) got_q.push_back(spi_if.tx_data);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    spi_if.rx_data  = b;
    spi_if.rx_valid = 1'b1;
    @(negedge sys_clk);
    spi_if.rx_valid = 1'b0;
  endtask

  task automatic pulse_wrap();
    @(negedge sys_clk);
    period_wrap = 1'b1;
    @(negedge sys_clk);
    period_wrap = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    spi_if.cs_n = 1'b1;
    spi_if.rx_valid = 1'b0;
    spi_if.rx_data = 8'h00;
    period_wrap = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_act[i] = 16'h0000;
    exp_en = '0;
    tick(3);
    total++; if (duty !== '0) begin bad++; $display("FAIL rst_duty: got %h want 0", duty); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_busy_err: got %b%b want 00", busy, err); end
    rst = 1'b0;
    tick(2);
    total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dbg_state_o); end
    total++; if (ch_en !== 7'h00 || dbg_pending_o !== 7'h00) begin bad++; $display("FAIL rst_en_pend: got %h/%h want 00/00", ch_en, dbg_pending_o); end
    total++; if (spi_if.tx_data !== 8'h00 || spi_if.tx_load !== 1'b0) begin bad++; $display("FAIL rst_tx: got %h/%b want 00/0", spi_if.tx_data, spi_if.tx_load); end
  endtask

  task automatic test_write_wrap();
    spi_if.cs_n = 1'b0;
    tick(1);
    send_byte(8'h88); send_byte(8'h12); send_byte(8'h34);
    tick(2);
    total++; if (duty[47:32] !== 16'h0000) begin bad++; $display("FAIL wr_before_wrap: got %h want 0000", duty[47:32]); end
    total++; if (dbg_pending_o !== 7'b0000100) begin bad++; $display("FAIL wr_pending: got %b want 0000100", dbg_pending_o); end
    pulse_wrap();
    exp_act[2] = 16'h1234;
    total++; if (duty[47:32] !== 16'h1234) begin bad++; $display("FAIL wr_after_wrap: got %h want 1234", duty[47:32]); end
    total++; if (dbg_pending_o !== 7'b0 || duty !== exp_duty_vec()) begin bad++; $display("FAIL wr_all: got %h/%b want %h/0", duty, dbg_pending_o, exp_duty_vec()); end
  endtask

  task automatic test_readback();
    int base;
    base = err_cnt;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    tick(2);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rd_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (dbg_state_o !== IDLE || err_cnt !== base) begin bad++; $display("FAIL rd_end: state %0d err %0d want IDLE %0d", dbg_state_o, err_cnt, base); end
    // cs_n toggling while idle is not an abort
    spi_if.cs_n = 1'b1; tick(2); spi_if.cs_n = 1'b0; tick(1);
    total++; if (err_cnt !== base) begin bad++; $display("FAIL idle_csn: err %0d want %0d", err_cnt, base); end
  endtask

  task automatic test_bad_cmd();
    int base;
    base = err_cnt;
    send_byte(8'h9C);
    tick(2);
    total++; if (err_cnt !== base + 1 || dbg_state_o !== IDLE) begin bad++; $display("FAIL bad_ch7: err %0d state %0d want %0d IDLE", err_cnt, dbg_state_o, base + 1); end
    send_byte(8'h82);
    tick(2);
    total++; if (err_cnt !== base + 2 || dbg_state_o !== IDLE) begin bad++; $display("FAIL bad_sel: err %0d state %0d want %0d IDLE", err_cnt, dbg_state_o, base + 2); end
    // byte while cs_n high is ignored
    spi_if.cs_n = 1'b1;
    send_byte(8'h88);
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL csn_high_ignored: busy %b want 0", busy); end
    spi_if.cs_n = 1'b0;
    tick(1);
    total++; if (dbg_pending_o !== 7'b0) begin bad++; $display("FAIL bad_pending: got %b want 0", dbg_pending_o); end
    pulse_wrap();
    total++; if (duty !== exp_duty_vec() || ch_en !== exp_en) begin bad++; $display("FAIL bad_noshadow: got %h/%b want %h/%b", duty, ch_en, exp_duty_vec(), exp_en); end
  endtask

  task automatic test_abort();
    int base;
    base = err_cnt;
    send_byte(8'h85); send_byte(8'h00);
    total++; if (dbg_state_o !== WR_LO || busy !== 1'b1) begin bad++; $display("FAIL abort_pre: state %0d busy %b want WR_LO 1", dbg_state_o, busy); end
    spi_if.cs_n = 1'b1;
    tick(2);
    total++; if (err_cnt !== base + 1) begin bad++; $display("FAIL abort_err: got %0d want %0d", err_cnt, base + 1); end
    total++; if (busy !== 1'b0 || dbg_pending_o !== 7'b0) begin bad++; $display("FAIL abort_idle: busy %b pend %b want 0 0", busy, dbg_pending_o); end
    pulse_wrap();
    total++; if (ch_en[1] !== 1'b0) begin bad++; $display("FAIL abort_en: got %b want 0", ch_en[1]); end
    spi_if.cs_n = 1'b0;
    tick(1);
  endtask

  task automatic test_ctrl();
    send_byte(8'h85); send_byte(8'h00); send_byte(8'h01);
    tick(2);
    total++; if (ch_en !== 7'b0 || dbg_pending_o !== 7'b0000010) begin bad++; $display("FAIL ctrl_pre: en %b pend %b want 0 0000010", ch_en, dbg_pending_o); end
    pulse_wrap();
    exp_en = 7'b0000010;
    total++; if (ch_en !== exp_en) begin bad++; $display("FAIL ctrl_en: got %b want %b", ch_en, exp_en); end
    got_q.delete(); exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_byte(8'h05); send_byte(8'hA5); send_byte(8'h5A);
    tick(2);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL ctrl_rd_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ctrl_rd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_coincidence();
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF);
    // now in the COMMIT cycle
    period_wrap = 1'b1;
    @(negedge sys_clk);
    period_wrap = 1'b0;
    #1;
    exp_act[0] = 16'hFFFF;
    total++; if (duty[15:0] !== 16'hFFFF) begin bad++; $display("FAIL coin_duty: got %h want ffff", duty[15:0]); end
    total++; if (dbg_pending_o !== 7'b0 || duty !== exp_duty_vec()) begin bad++; $display("FAIL coin_pend: pend %b duty %h want 0 %h", dbg_pending_o, duty, exp_duty_vec()); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h90); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h94); send_byte(8'h0F); send_byte(8'hF0);
    tick(2);
    total++; if (dbg_pending_o !== 7'b0110000 || duty !== exp_duty_vec()) begin bad++; $display("FAIL b2b_pre: pend %b duty %h want 0110000 %h", dbg_pending_o, duty, exp_duty_vec()); end
    pulse_wrap();
    exp_act[4] = 16'hAA55;
    exp_act[5] = 16'h0FF0;
    total++; if (duty !== exp_duty_vec() || dbg_pending_o !== 7'b0) begin bad++; $display("FAIL b2b_post: duty %h pend %b want %h 0", duty, dbg_pending_o, exp_duty_vec()); end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h8C); send_byte(8'hAB);
    total++; if (dbg_state_o !== WR_LO) begin bad++; $display("FAIL rmf_pre: state %0d want WR_LO", dbg_state_o); end
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < NUM_CH; i++) exp_act[i] = 16'h0000;
    exp_en = '0;
    total++; if (duty !== '0 || ch_en !== 7'b0 || dbg_pending_o !== 7'b0) begin bad++; $display("FAIL rmf_regs: duty %h en %b pend %b want 0", duty, ch_en, dbg_pending_o); end
    total++; if (busy !== 1'b0 || err !== 1'b0 || spi_if.tx_load !== 1'b0 || spi_if.tx_data !== 8'h00) begin bad++; $display("FAIL rmf_outs: busy %b err %b load %b tx %h want 0 0 0 00", busy, err, spi_if.tx_load, spi_if.tx_data); end
    rst = 1'b0;
    tick(1);
    send_byte(8'h8C); send_byte(8'h56); send_byte(8'h78);
    pulse_wrap();
    exp_act[3] = 16'h5678;
    total++; if (duty !== exp_duty_vec()) begin bad++; $display("FAIL rmf_next: duty %h want %h", duty, exp_duty_vec()); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_wrap();
    test_readback();
    test_bad_cmd();
    test_abort();
    test_ctrl();
    test_coincidence();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
